// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: one buffered byte together with
// the error flags that RxUnit reported for its frame.
package uart_pkg;

    typedef struct packed {
        logic [2:0] err;
        logic [7:0] data;
    } rx_entry_t;

    localparam int ERR_PARITY = 2;
    localparam int ERR_START  = 1;
    localparam int ERR_STOP   = 0;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for level signals that cross into the system
// clock domain. It is shared by the Rx and Tx sides of the UART.
module uart_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage1 <= '0;
            stage2 <= '0;
        end else begin
            stage1 <= d;
            stage2 <= stage1;
        end
    end

    assign q = stage2;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind RxUnit: captures each completed frame with its error
// flags and presents the oldest entry to the core as first-word-fall-through data.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int IRQ_LEVEL = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   done_flag,
    input  logic [7:0]             rx_data,
    input  logic [2:0]             rx_error,
    input  logic                   rd_en,
    input  logic                   clr_overrun,
    output logic [7:0]             rd_data,
    output logic [2:0]             rd_error,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    output logic                   irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic      done_sync;
    logic      done_prev;
    logic      wr_pulse;
    logic      do_wr;
    logic      do_rd;
    logic      overflow;
    ptr_t      wr_ptr;
    ptr_t      rd_ptr;
    ptr_t      wr_ptr_next;
    ptr_t      rd_ptr_next;
    cnt_t      count_next;
    logic      overrun_next;
    rx_entry_t wr_entry;
    rx_entry_t head;
    rx_entry_t mem [DEPTH];

    uart_sync2 #(
        .WIDTH (1)
    ) u_done_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (done_flag),
        .q       (done_sync)
    );

    // Third flop turns the synchronised level into a single-cycle write strobe,
    // so a done_flag held high for many clocks produces only one entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_prev <= 1'b0;
        end else begin
            done_prev <= done_sync;
        end
    end

    assign wr_pulse = done_sync & ~done_prev;

    // A write into a full FIFO is still accepted when the same cycle frees a slot.
    always_comb begin
        wr_entry.err  = rx_error;
        wr_entry.data = rx_data;
        do_rd         = rd_en & ~empty;
        do_wr         = wr_pulse & (~full | do_rd);
        overflow      = wr_pulse & full & ~do_rd;
        wr_ptr_next   = do_wr ? wr_ptr + ptr_t'(1) : wr_ptr;
        rd_ptr_next   = do_rd ? rd_ptr + ptr_t'(1) : rd_ptr;

        count_next = count;
        case ({do_wr, do_rd})
            2'b10:   count_next = count + cnt_t'(1);
            2'b01:   count_next = count - cnt_t'(1);
            default: count_next = count;
        endcase

        overrun_next = overrun;
        if (overflow) begin
            overrun_next = 1'b1;
        end else if (clr_overrun) begin
            overrun_next = 1'b0;
        end
    end

    // Status flags come from next-state count so they never lag count itself.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            irq     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            count   <= count_next;
            empty   <= (count_next == '0);
            full    <= (count_next == cnt_t'(DEPTH));
            irq     <= (count_next >= cnt_t'(IRQ_LEVEL));
            overrun <= overrun_next;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Head register tracks mem[rd_ptr]; the bypass covers a write landing on the new head slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
        end else if (do_wr && (wr_ptr == rd_ptr_next)) begin
            head <= wr_entry;
        end else begin
            head <= mem[rd_ptr_next];
        end
    end

    assign rd_data  = head.data;
    assign rd_error = head.err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a scoreboard queue predicts every head
// entry, and a vector table drives the fill/overflow walk.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    typedef struct {
        logic [7:0] data;
        logic [2:0] err;
        bit         rd;
        bit         clr;
        int         exp_count;
        logic       exp_full;
        logic       exp_overrun;
        logic       exp_irq;
    } vec_t;

    logic       clock       = 1'b0;
    logic       reset_n     = 1'b0;
    logic       done_flag   = 1'b0;
    logic [7:0] rx_data     = '0;
    logic [2:0] rx_error    = '0;
    logic       rd_en       = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [7:0] rd_data;
    logic [2:0] rd_error;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       irq;

    int        n_checks = 0;
    int        n_fail   = 0;
    rx_entry_t exp_q[$];
    logic      model_overrun = 1'b0;
    vec_t      tbl [17];

    uart_rx_fifo #(
        .DEPTH     (DEPTH),
        .IRQ_LEVEL (1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .done_flag   (done_flag),
        .rx_data     (rx_data),
        .rx_error    (rx_error),
        .rd_en       (rd_en),
        .clr_overrun (clr_overrun),
        .rd_data     (rd_data),
        .rd_error    (rd_error),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .irq         (irq)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check_output({tag, "_count"}, 32'(count), 32'(exp_q.size()));
        check_output({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check_output({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
        check_output({tag, "_irq"}, 32'(irq), 32'(exp_q.size() >= 1));
        check_output({tag, "_overrun"}, 32'(overrun), 32'(model_overrun));
    endtask

    // One frame from RxUnit; optional rd_en / clr_overrun land in the strobe cycle.
    task automatic apply_stimulus(input logic [7:0] d, input logic [2:0] e,
                                  input bit rd_in_pulse, input bit clr_in_pulse, input int hold);
        rx_entry_t ent;
        rx_entry_t popped;
        @(posedge clock);
        #1;
        rx_data   = d;
        rx_error  = e;
        done_flag = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        if (rd_in_pulse) rd_en = 1'b1;
        if (clr_in_pulse) clr_overrun = 1'b1;
        if (rd_in_pulse && exp_q.size() > 0) begin
            popped = exp_q.pop_front();
            check_output("simul_rd_data", 32'(rd_data), 32'(popped.data));
            check_output("simul_rd_error", 32'(rd_error), 32'(popped.err));
        end
        if (exp_q.size() < DEPTH) begin
            ent.err  = e;
            ent.data = d;
            exp_q.push_back(ent);
            if (clr_in_pulse) model_overrun = 1'b0;
        end else begin
            model_overrun = 1'b1;
        end
        @(posedge clock);
        #1;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        for (int i = 3; i < hold; i++) begin
            @(posedge clock);
            #1;
        end
        done_flag = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic pop_entry(input string tag);
        rx_entry_t exp_head;
        if (exp_q.size() == 0) return;
        exp_head = exp_q.pop_front();
        check_output({tag, "_empty"}, 32'(empty), 32'(0));
        check_output({tag, "_data"}, 32'(rd_data), 32'(exp_head.data));
        check_output({tag, "_error"}, 32'(rd_error), 32'(exp_head.err));
        rd_en = 1'b1;
        @(posedge clock);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_overrun = 1'b1;
        @(posedge clock);
        #1;
        clr_overrun   = 1'b0;
        model_overrun = 1'b0;
    endtask

    initial begin
        int waited;

        for (int i = 0; i < 16; i++) begin
            tbl[i].data        = 8'(i);
            tbl[i].err         = 3'(i);
            tbl[i].rd          = 1'b0;
            tbl[i].clr         = 1'b0;
            tbl[i].exp_count   = i + 1;
            tbl[i].exp_full    = (i == 15);
            tbl[i].exp_overrun = 1'b0;
            tbl[i].exp_irq     = 1'b1;
        end
        tbl[16] = '{8'hFF, 3'b000, 1'b0, 1'b0, 16, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_output("reset_count", 32'(count), 32'(0));
        check_output("reset_empty", 32'(empty), 32'(1));
        check_output("reset_full", 32'(full), 32'(0));
        check_output("reset_overrun", 32'(overrun), 32'(0));
        check_output("reset_irq", 32'(irq), 32'(0));
        check_output("reset_rd_data", 32'(rd_data), 32'(0));
        check_output("reset_rd_error", 32'(rd_error), 32'(0));
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // T1 single byte with latency bound
        rx_data   = 8'hA5;
        rx_error  = 3'b000;
        done_flag = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_output("t1_no_early_write", 32'(empty), 32'(1));
        waited = 0;
        while (empty && waited < 2) begin
            @(posedge clock);
            #1;
            waited++;
        end
        check_output("t1_empty_fell", 32'(empty), 32'(0));
        begin
            rx_entry_t ent;
            ent.err  = 3'b000;
            ent.data = 8'hA5;
            exp_q.push_back(ent);
        end
        done_flag = 1'b0;
        check_output("t1_rd_data", 32'(rd_data), 32'h0A5);
        check_output("t1_rd_error", 32'(rd_error), 32'(0));
        check_output("t1_count", 32'(count), 32'(1));
        check_output("t1_irq", 32'(irq), 32'(1));
        pop_entry("t1_pop");
        check_output("t1_after_pop_empty", 32'(empty), 32'(1));
        check_output("t1_after_pop_count", 32'(count), 32'(0));
        repeat (4) @(posedge clock);
        #1;

        // Pop while empty is ignored
        rd_en = 1'b1;
        @(posedge clock);
        #1;
        rd_en = 1'b0;
        check_status("rd_while_empty");

        // T2 held level writes once
        apply_stimulus(8'h3C, 3'b000, 1'b0, 1'b0, 20);
        check_output("t2_count", 32'(count), 32'(1));
        pop_entry("t2_pop");
        check_status("t2_after");

        // T3 fill and overflow from the vector table
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(tbl[i].data, tbl[i].err, tbl[i].rd, tbl[i].clr, 4);
            check_output($sformatf("t3_vec%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
            check_output($sformatf("t3_vec%0d_full", i), 32'(full), 32'(tbl[i].exp_full));
            check_output($sformatf("t3_vec%0d_overrun", i), 32'(overrun), 32'(tbl[i].exp_overrun));
            check_output($sformatf("t3_vec%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
        end
        pulse_clr();
        check_output("t3_clr_while_full", 32'(overrun), 32'(0));
        apply_stimulus(8'hEE, 3'b000, 1'b0, 1'b1, 4);
        check_output("t3_set_beats_clr", 32'(overrun), 32'(1));
        check_output("t3_count_held", 32'(count), 32'(16));
        for (int i = 0; i < 16; i++) begin
            check_output($sformatf("t3_order%0d", i), 32'(rd_data), 32'(i));
            pop_entry("t3_drain");
        end
        check_output("t3_drained_empty", 32'(empty), 32'(1));
        check_output("t3_overrun_sticky", 32'(overrun), 32'(1));
        pulse_clr();
        check_output("t3_overrun_cleared", 32'(overrun), 32'(0));

        // T4 simultaneous pop and write while full
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(8'(8'h20 + i), 3'b010, 1'b0, 1'b0, 4);
        end
        check_status("t4_full");
        apply_stimulus(8'h55, 3'b000, 1'b1, 1'b0, 4);
        check_output("t4_count", 32'(count), 32'(16));
        check_output("t4_overrun", 32'(overrun), 32'(0));
        check_output("t4_full_flag", 32'(full), 32'(1));
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check_output("t4_last_is_55", 32'(rd_data), 32'h055);
            pop_entry("t4_drain");
        end
        check_status("t4_after");

        // T5 error passthrough, first frame also collides with a pop while empty
        apply_stimulus(8'h7E, 3'b100, 1'b1, 1'b0, 4);
        check_output("t5_empty_simul_count", 32'(count), 32'(1));
        apply_stimulus(8'h81, 3'b001, 1'b0, 1'b0, 4);
        check_output("t5_err_first", 32'(rd_error), 32'(3'b100));
        pop_entry("t5_pop");
        check_output("t5_err_second", 32'(rd_error), 32'(3'b001));
        pop_entry("t5_pop");
        check_status("t5_after");

        // T6 reset mid-operation with a frame in flight
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(8'(8'h40 + i), 3'b000, 1'b0, 1'b0, 4);
        end
        check_status("t6_before");
        @(posedge clock);
        #1;
        rx_data   = 8'hEE;
        done_flag = 1'b1;
        @(posedge clock);
        #1;
        reset_n   = 1'b0;
        done_flag = 1'b0;
        #1;
        check_output("t6_async_count", 32'(count), 32'(0));
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        model_overrun = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check_status("t6_after_reset");
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(8'(8'h12 + i), 3'(i), 1'b0, 1'b0, 4);
            if (i == 0) check_output("t6_first_byte", 32'(rd_data), 32'h012);
            pop_entry("t6_wrap");
        end
        check_status("t6_wrapped");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
